input_buffer_sender: RTL and testbench

- Write-side formatter for the MobileNet accelerator input buffer.
- Receives DRAM read bursts (rvalid/rdata) while loading is enabled and turns each beat into one registered write (data, bank, row, column) into the input-tile buffer.
- Each burst carries one input-tile row. The tile is IH rows by IW columns:
  - IW = (POX-1)*STRIDE+KSIZE
  - IH = (POY-1)*STRIDE+KSIZE
- Rows are interleaved over KSIZE banks.

---
 rtl/input_buffer_sender.sv | 145 ++++++++++++++
 tb/tb_input_buffer_sender.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/input_buffer_sender.sv
// Write-side formatter for the input-tile buffer.
// Maps DRAM read beats to registered (data, bank, row, column) writes.
module input_buffer_sender #(
  parameter int DW     = 32,
  parameter int STRIDE = 2,
  parameter int POY    = 4,
  parameter int POX    = 15,
  parameter int KSIZE  = 3,
  parameter int BURST  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_load,
  input  logic          rvalid,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] wdata,
  output logic [7:0]    wbank,
  output logic [7:0]    wrow,
  output logic [27:0]   wcol
);

  localparam int IW = (POX - 1) * STRIDE + KSIZE;
  localparam int IH = (POY - 1) * STRIDE + KSIZE;

  localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int ROW_W  = (IH > 1) ? $clog2(IH) : 1;
  localparam int BSEL_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  generate
    if (KSIZE > 8 || KSIZE < 1) begin : g_bad_ksize
      $error("input_buffer_sender: KSIZE must be 1..8");
    end
    if (BURST < IW) begin : g_bad_burst
      $error("input_buffer_sender: BURST must be >= IW");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t state, state_nx;

  logic [BEAT_W-1:0] beat, beat_nx;
  logic [ROW_W-1:0]  row, row_nx;
  logic [BSEL_W-1:0] bsel, bsel_nx;
  logic [ROW_W-1:0]  grp, grp_nx;

  logic              accept;
  logic              last_beat;
  logic              pad;
  logic [7:0]        onehot;
  logic [ROW_W+7:0]  grp_ext;
  logic [BEAT_W+27:0] col_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (data_load)  state_nx = LOAD;
      LOAD:    if (!data_load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = data_load && rvalid;
  assign last_beat = (beat == BEAT_W'(BURST - 1));

  // bsel/grp track row % KSIZE and row / KSIZE without a divider
  always_comb begin
    beat_nx = beat;
    row_nx  = row;
    bsel_nx = bsel;
    grp_nx  = grp;
    if (state_nx == IDLE) begin
      beat_nx = '0;
      row_nx  = '0;
      bsel_nx = '0;
      grp_nx  = '0;
    end else if (accept) begin
      if (!last_beat) begin
        beat_nx = beat + 1'b1;
      end else begin
        beat_nx = '0;
        if (row == ROW_W'(IH - 1)) begin
          row_nx  = '0;
          bsel_nx = '0;
          grp_nx  = '0;
        end else begin
          row_nx = row + 1'b1;
          if (bsel == BSEL_W'(KSIZE - 1)) begin
            bsel_nx = '0;
            grp_nx  = grp + 1'b1;
          end else begin
            bsel_nx = bsel + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
      row  <= '0;
      bsel <= '0;
      grp  <= '0;
    end else begin
      beat <= beat_nx;
      row  <= row_nx;
      bsel <= bsel_nx;
      grp  <= grp_nx;
    end
  end

  assign pad     = (32'(beat) >= IW);
  assign onehot  = 8'd1 << bsel;
  assign grp_ext = {8'd0, grp};
  assign col_ext = {28'd0, beat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata <= '0;
      wbank <= '0;
      wrow  <= '0;
      wcol  <= '0;
    end else if (accept) begin
      wdata <= rdata;
      wbank <= pad ? 8'd0 : onehot;
      wrow  <= grp_ext[7:0];
      wcol  <= col_ext[27:0];
    end else begin
      wbank <= '0;
    end
  end

endmodule

// File: tb/tb_input_buffer_sender.sv
// Directed bench for input_buffer_sender.
// Default parameters: IW=31, IH=9, KSIZE=3, BURST=32.
module tb_input_buffer_sender;

  logic        clk;
  logic        rst_n;
  logic        data_load;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [7:0]  wbank;
  logic [7:0]  wrow;
  logic [27:0] wcol;

  int vectors;
  int miscompares;

  logic [7:0] eb [10];
  logic [7:0] er [10];

  input_buffer_sender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_load (data_load),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .wdata     (wdata),
    .wbank     (wbank),
    .wrow      (wrow),
    .wcol      (wcol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic dl, input logic rv,
                     input logic [31:0] d);
    data_load = dl;
    rvalid    = rv;
    rdata     = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] xb,
                     input logic [7:0] xr, input logic [27:0] xc,
                     input logic [31:0] xd);
    vectors++;
    assert (wbank === xb) else begin
      miscompares++;
      $error("FAIL %s wbank got %0h want %0h", tag, wbank, xb);
    end
    assert (wrow === xr) else begin
      miscompares++;
      $error("FAIL %s wrow got %0h want %0h", tag, wrow, xr);
    end
    assert (wcol === xc) else begin
      miscompares++;
      $error("FAIL %s wcol got %0h want %0h", tag, wcol, xc);
    end
    assert (wdata === xd) else begin
      miscompares++;
      $error("FAIL %s wdata got %0h want %0h", tag, wdata, xd);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    eb = '{8'h01, 8'h02, 8'h04, 8'h01, 8'h02,
           8'h04, 8'h01, 8'h02, 8'h04, 8'h01};
    er = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1,
           8'd1, 8'd2, 8'd2, 8'd2, 8'd0};
    rst_n     = 1'b0;
    data_load = 1'b0;
    rvalid    = 1'b0;
    rdata     = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 8'h00, 8'd0, 28'd0, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'hffff_ffff);
      chk("load_no_valid", 8'h00, 8'd0, 28'd0, 32'd0);
    end

    // ten bursts: rows 0..8 then wrap to row 0
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 32; i++) begin
        cyc(1'b1, 1'b1, 32'(k * 64 + i));
        chk($sformatf("burst%0d_b%0d", k, i),
            (i < 31) ? eb[k] : 8'h00, er[k],
            28'(i), 32'(k * 64 + i));
      end
    end
    cyc(1'b1, 1'b0, 32'h1234_5678);
    chk("hold", 8'h00, 8'd0, 28'd31, 32'd607);

    // row 1 with rvalid gaps
    for (int i = 0; i < 32; i++) begin
      if (i == 5 || i == 20) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b1, 1'b0, 32'hbad0_0000);
          chk($sformatf("gap_b%0d", i), 8'h00, 8'd0,
              28'(i - 1), 32'(1000 + i - 1));
        end
      end
      cyc(1'b1, 1'b1, 32'(1000 + i));
      chk($sformatf("gapburst_b%0d", i),
          (i < 31) ? 8'h02 : 8'h00, 8'd0,
          28'(i), 32'(1000 + i));
    end

    // row 2, abort after beat 10
    for (int i = 0; i <= 10; i++) begin
      cyc(1'b1, 1'b1, 32'(2000 + i));
      chk($sformatf("abort_b%0d", i), 8'h04, 8'd0,
          28'(i), 32'(2000 + i));
    end
    cyc(1'b0, 1'b1, 32'hdead_beef);
    chk("drop", 8'h00, 8'd0, 28'd10, 32'd2010);
    cyc(1'b1, 1'b1, 32'd3000);
    chk("reraise", 8'h01, 8'd0, 28'd0, 32'd3000);
    cyc(1'b1, 1'b1, 32'd3001);
    cyc(1'b1, 1'b1, 32'd3002);
    chk("reraise_b2", 8'h01, 8'd0, 28'd2, 32'd3002);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 8'h00, 8'd0, 28'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 32'd4000);
    chk("post_rst", 8'h01, 8'd0, 28'd0, 32'd4000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
